// File: rtl/m68k_bus_master_pkg.sv
// Shared definitions for the 68000-style asynchronous bus master: FSM state
// encoding, timeout defaults and the strobe-phase decode used by the top.
package m68k_bus_master_pkg;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;
  localparam int TMO_CNT_W              = 8;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_ADDR   = 3'd1;
  localparam state_t S_ASSERT = 3'd2;
  localparam state_t S_WAIT   = 3'd3;
  localparam state_t S_DATA   = 3'd4;
  localparam state_t S_TERM   = 3'd5;

  // Writes hold UDS_n/LDS_n off for one extra cycle so DOUT settles first.
  function automatic logic strobes_on(input state_t s, input logic we);
    return (s == S_WAIT) || (s == S_DATA) || ((s == S_ASSERT) && !we);
  endfunction

endpackage

// File: rtl/bus_timeout.sv
// WAIT-state watchdog: counts cycles while enabled and flags the cycle whose
// increment reaches LIMIT, so the master gives up after exactly LIMIT waits.
module bus_timeout
  import m68k_bus_master_pkg::*;
#(
  parameter int LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [TMO_CNT_W-1:0] r_count;

  // NOTE: sequential state is written with <= only, so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != TMO_CNT_W'(LIMIT))) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_enable && (r_count == TMO_CNT_W'(LIMIT - 1));

endmodule

// File: rtl/m68k_bus_master.sv
// Single-request 68000 bus master: turns a req/ack handshake into one
// AS_n/UDS_n/LDS_n/DTACK_n bus cycle, with a timeout for missing DTACK_n.
module m68k_bus_master
  import m68k_bus_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        CLK,
  input  logic        RESET_n,
  // request side
  input  logic        req,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [22:0] req_addr,   // A23:A1
  input  logic [1:0]  req_be,     // bit1 = upper byte, bit0 = lower byte
  input  logic [15:0] req_wdata,
  output logic        ack,
  output logic        err,
  output logic [15:0] rdata,
  // 68000 bus side
  output logic [22:0] ADDR,
  output logic        AS_n,
  output logic        UDS_n,
  output logic        LDS_n,
  output logic        RW,
  output logic [15:0] DOUT,
  output logic        DOE,
  input  logic [15:0] DIN,
  input  logic        DTACK_n
);

  state_t      r_state;
  logic        r_we;
  logic [1:0]  r_be;
  logic [22:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic        r_ack;
  logic        r_err;

  logic w_start;
  logic w_reject;
  logic w_tmo_en;
  logic w_expired;
  logic w_busy;
  logic w_as;
  logic w_strobe;

  assign w_start  = (r_state == S_IDLE) && req && (req_be != 2'b00);
  assign w_reject = (r_state == S_IDLE) && req && (req_be == 2'b00);
  assign w_tmo_en = (r_state == S_WAIT) && DTACK_n;

  bus_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (CLK),
    .rst_n     (RESET_n),
    .i_clear   (w_start),
    .i_enable  (w_tmo_en),
    .o_expired (w_expired)
  );

  // NOTE: the latched request and rdata are plain registers, not a memory,
  // so they take the async reset; that is what makes ADDR/DOUT/rdata read 0.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_be    <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= w_reject;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_we    <= req_we;
            r_be    <= req_be;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_state <= S_ADDR;
          end
        end
        S_ADDR:   r_state <= S_ASSERT;
        S_ASSERT: r_state <= S_WAIT;
        S_WAIT: begin
          if (!DTACK_n) begin
            r_state <= S_DATA;
          end else if (w_expired) begin
            r_state <= S_TERM;
            r_err   <= 1'b1;
          end
        end
        S_DATA: begin
          if (!r_we) begin
            r_rdata <= DIN;
          end
          r_ack   <= 1'b1;
          r_state <= S_TERM;
        end
        S_TERM: begin
          // The slave must release DTACK_n before the next cycle may start.
          if (DTACK_n) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bus controls decode straight from registered state, so reset reaches
  // the pins in the same instant it clears r_state.
  assign w_busy   = (r_state != S_IDLE);
  assign w_as     = (r_state == S_ASSERT) || (r_state == S_WAIT) || (r_state == S_DATA);
  assign w_strobe = strobes_on(r_state, r_we);

  assign req_ready = !w_busy;
  assign AS_n      = !w_as;
  assign UDS_n     = !(w_strobe && r_be[1]);
  assign LDS_n     = !(w_strobe && r_be[0]);
  assign RW        = !(w_busy && r_we);
  assign DOE       = w_busy && r_we;
  assign ADDR      = r_addr;
  assign DOUT      = r_wdata;
  assign rdata     = r_rdata;
  assign ack       = r_ack;
  assign err       = r_err;

endmodule

// File: doc/m68k_bus_master.md
M68K_BUS_MASTER -- requirements
Module: m68k_bus_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: max WAIT cycles without DTACK_n before error termination (range 2..255).
REQ-002 SHALL have ports: CLK  in  1  sole clock, all logic on rising edge.
REQ-003 SHALL have ports: RESET_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: req  in  1 / req_ready  out  1 / req_we  in  1 / req_addr  in  23 (A23:A1) / req_be  in  2 (bit1=upper, bit0=lower) / req_wdata  in  16.
REQ-005 SHALL have ports: ack  out  1  one-cycle done pulse / err  out  1  one-cycle error pulse / rdata  out  16  read data.
REQ-006 SHALL have ports: ADDR  out  23 / AS_n  out  1 / UDS_n  out  1 / LDS_n  out  1 / RW  out  1 / DOUT  out  16 / DOE  out  1  data-bus drive enable / DIN  in  16 / DTACK_n  in  1 (same clock domain, no synchroniser).

Function
REQ-007 SHALL implement FSM states IDLE, ADDR, ASSERT, WAIT, DATA, TERM; one state per CLK except WAIT and TERM.
REQ-008 IDLE: req_ready=1; AS_n=UDS_n=LDS_n=RW=1, DOE=0; req=1 latches addr/we/be/wdata and enters ADDR next cycle.
REQ-009 req in any non-IDLE state SHALL be ignored; no queueing.
REQ-010 req with req_be=00 SHALL not start a bus cycle; err pulses the next cycle, FSM stays IDLE.
REQ-011 ADDR: ADDR driven with latched address (held until IDLE); RW=!we; DOE=we, DOUT=wdata.
REQ-012 ASSERT: AS_n=0; read: UDS_n/LDS_n = !be; write: data strobes remain negated.
REQ-013 WAIT: AS_n=0, strobes = !be for reads and writes; DTACK_n=0 sampled -> DATA; else wait counter increments.
REQ-014 Wait counter SHALL clear on ADDR entry; when it reaches TIMEOUT_CYCLES with DTACK_n still 1 -> TERM with error flag set.
REQ-015 DATA: strobes held one cycle; on read, rdata <= DIN at end of this cycle.
REQ-016 TERM: AS_n, UDS_n, LDS_n negated; DOE held 1 for writes (data hold); ack (or err on timeout, never both) pulses on first TERM cycle only.
REQ-017 TERM SHALL remain until DTACK_n=1, then -> IDLE with RW=1, DOE=0; timeout case exits immediately if DTACK_n=1.
REQ-018 Minimum latency: req to ack = 5 cycles with DTACK_n already 0 in WAIT's first cycle; back-to-back cycles separated by >=1 IDLE cycle.
REQ-019 rdata SHALL hold its value until the next completed read; unchanged on writes and errors.
REQ-020 DTACK_n low during IDLE/ADDR/ASSERT SHALL be ignored (only sampled in WAIT and TERM).

Reset
REQ-021 RESET_n low SHALL immediately force IDLE: AS_n=UDS_n=LDS_n=RW=1, DOE=0, ack=err=0, ADDR=0, DOUT=0, rdata=0, counter=0.
REQ-022 Reset mid-cycle SHALL abort with no ack/err pulse; first request after release starts a fresh cycle.

Structure
REQ-023 Shared package SHALL hold the state enum, default TIMEOUT_CYCLES and timeout-counter width constant.
REQ-024 Timeout counter SHALL be one sub-module, bus_timeout (clear, enable, expired output).

Verification
REQ-025 Read, be=11, addr=0x7F0000>>1, DTACK_n=0 from WAIT cycle 1, DIN=0xA55A -> ack at cycle 5, rdata=0xA55A, UDS_n/LDS_n low in ASSERT+WAIT+DATA.
REQ-026 Write, be=10, wdata=0x1234, DTACK_n delayed 3 cycles -> UDS_n low from WAIT only, LDS_n high throughout, DOE=1 ADDR..TERM, ack at cycle 8.
REQ-027 No DTACK_n, TIMEOUT_CYCLES=64 -> err pulse after 64 WAIT cycles, no ack, rdata unchanged.
REQ-028 DTACK_n held low 4 cycles after strobes negate -> FSM stays TERM 4 cycles, single ack, req_ready=0 until IDLE.
REQ-029 RESET_n low during WAIT -> AS_n/UDS_n/LDS_n/RW=1, DOE=0 same instant; no ack; next req completes normally.
REQ-030 req_be=00 -> err next cycle, AS_n never asserted; req held high while busy -> exactly one bus cycle.
